// File: rtl/chrom_pkg.sv
// Shared sizing helpers, FSM state type and flat-payload offset functions
// for the serial chromosome loader.
package chrom_pkg;

    localparam int DEF_ROW = 2;
    localparam int DEF_COL = 1;
    localparam int DEF_OUT = 2;

    function automatic int calc_sel_w(input int cells);
        return (cells > 1) ? $clog2(cells) : 1;
    endfunction

    localparam int SEL_W   = calc_sel_w(DEF_ROW * DEF_COL);
    localparam int CHROM_W = DEF_ROW * DEF_COL * 16 + DEF_OUT * SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_CHECK
    } state_e;

    // Cell (r,c) truth table starts at bit (r*col+c)*16 of the payload.
    function automatic int unsigned tt_off(input int unsigned r, input int unsigned c,
                                           input int unsigned col);
        return (r * col + c) * 16;
    endfunction

    function automatic int unsigned sel_off(input int unsigned k, input int unsigned row,
                                            input int unsigned col, input int unsigned sel_w);
        return row * col * 16 + k * sel_w;
    endfunction

endpackage

// File: rtl/chrom_serial_loader_chrom_check.sv
// Combinational frame validation: even parity over the payload and
// every output selector must address an existing cell.
module chrom_check
    import chrom_pkg::*;
#(
    parameter int ROW     = DEF_ROW,
    parameter int COL     = DEF_COL,
    parameter int OUT     = DEF_OUT,
    parameter int SEL_W   = calc_sel_w(ROW * COL),
    parameter int CHROM_W = ROW * COL * 16 + OUT * SEL_W
) (
    input  logic [CHROM_W-1:0] shadow_i,
    input  logic               rx_par_i,
    output logic               err_o
);

    localparam logic [SEL_W:0] CELLS = (SEL_W + 1)'(ROW * COL);

    logic [SEL_W:0] sel_ext;

    always_comb begin
        err_o   = ((^shadow_i) != rx_par_i);
        sel_ext = '0;
        for (int unsigned k = 0; k < OUT; k++) begin
            sel_ext = {1'b0, shadow_i[sel_off(k, ROW, COL, SEL_W) +: SEL_W]};
            if (sel_ext >= CELLS) err_o = 1'b1;
        end
    end

endmodule

// File: rtl/chrom_serial_loader.sv
// Bit-serial chromosome loader: shifts a frame into a shadow register,
// validates it, and atomically commits it to the circuit-facing registers.
module chrom_serial_loader
    import chrom_pkg::*;
#(
    parameter int ROW     = DEF_ROW,
    parameter int COL     = DEF_COL,
    parameter int OUT     = DEF_OUT,
    parameter int SEL_W   = calc_sel_w(ROW * COL),
    parameter int CHROM_W = ROW * COL * 16 + OUT * SEL_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic                             ser_data,
    input  logic                             ser_valid,
    output logic                             ser_ready,
    output logic [ROW-1:0][COL-1:0][15:0]    saidas_LE,
    output logic [OUT-1:0][SEL_W-1:0]        out_chrom,
    output logic                             chrom_valid,
    output logic                             load_done,
    output logic                             load_err
);

    localparam int CNT_W = $clog2(CHROM_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHROM_W - 1);

    state_e               state_q;
    logic [CHROM_W-1:0]   shadow_q;
    logic [CHROM_W-1:0]   active_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 rx_par_q;
    logic                 ser_ready_q;
    logic                 chrom_valid_q;
    logic                 load_done_q;
    logic                 load_err_q;
    logic                 frame_err;
    logic                 accept;

    assign accept = ser_valid && ser_ready_q;

    chrom_check #(
        .ROW     (ROW),
        .COL     (COL),
        .OUT     (OUT),
        .SEL_W   (SEL_W),
        .CHROM_W (CHROM_W)
    ) u_check (
        .shadow_i (shadow_q),
        .rx_par_i (rx_par_q),
        .err_o    (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            active_q      <= '0;
            cnt_q         <= '0;
            rx_par_q      <= 1'b0;
            ser_ready_q   <= 1'b0;
            chrom_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        shadow_q    <= '0;
                        cnt_q       <= '0;
                        state_q     <= ST_SHIFT;
                        ser_ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A restart outranks a bit offered in the same cycle.
                    if (load_start) begin
                        shadow_q <= '0;
                        cnt_q    <= '0;
                    end else if (accept) begin
                        shadow_q[cnt_q] <= ser_data;
                        if (cnt_q == CNT_LAST) state_q <= ST_PARITY;
                        else                   cnt_q   <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (load_start) begin
                        shadow_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_SHIFT;
                    end else if (accept) begin
                        rx_par_q    <= ser_data;
                        state_q     <= ST_CHECK;
                        ser_ready_q <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    if (frame_err) begin
                        load_err_q <= 1'b1;
                    end else begin
                        active_q      <= shadow_q;
                        chrom_valid_q <= 1'b1;
                        load_done_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        saidas_LE = '0;
        out_chrom = '0;
        for (int unsigned r = 0; r < ROW; r++)
            for (int unsigned c = 0; c < COL; c++)
                saidas_LE[r][c] = active_q[tt_off(r, c, COL) +: 16];
        for (int unsigned k = 0; k < OUT; k++)
            out_chrom[k] = active_q[sel_off(k, ROW, COL, SEL_W) +: SEL_W];
    end

    assign ser_ready   = ser_ready_q;
    assign chrom_valid = chrom_valid_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed bench for chrom_serial_loader: default geometry plus a 3x1
// instance for the selector range check.
module tb_chrom_serial_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ls = 1'b0;
    logic ls3 = 1'b0;
    logic ser_data = 1'b0;
    logic ser_valid = 1'b0;

    logic                 ready, valid, done, err;
    logic [1:0][0:0][15:0] saidas;
    logic [1:0][0:0]       outc;

    logic                 ready3, valid3, done3, err3;
    logic [2:0][0:0][15:0] saidas3;
    logic [1:0][1:0]       outc3;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chrom_serial_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(ls), .ser_data(ser_data),
        .ser_valid(ser_valid), .ser_ready(ready), .saidas_LE(saidas),
        .out_chrom(outc), .chrom_valid(valid), .load_done(done), .load_err(err)
    );

    chrom_serial_loader #(.ROW(3), .COL(1), .OUT(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_start(ls3), .ser_data(ser_data),
        .ser_valid(ser_valid), .ser_ready(ready3), .saidas_LE(saidas3),
        .out_chrom(outc3), .chrom_valid(valid3), .load_done(done3), .load_err(err3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit which, output int e);
        @(negedge clk);
        if (which) ls3 = 1'b1; else ls = 1'b1;
        @(negedge clk);
        e = cyc;
        ls = 1'b0;
        ls3 = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] p, input int n, input int gap_at, input int gap_len);
        logic [63:0] v;
        v = p;
        for (int i = 0; i < n; i++) begin
            ser_valid = 1'b1;
            ser_data  = v[i];
            @(negedge clk);
            if (i == gap_at) begin
                ser_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic wait_result(input bit which, output int edge_no, output bit sd, output bit se);
        sd = 1'b0;
        se = 1'b0;
        edge_no = -1;
        for (int i = 0; i < 200; i++) begin
            if (which ? (done3 || err3) : (done || err)) begin
                sd = which ? done3 : done;
                se = which ? err3 : err;
                edge_no = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    localparam logic [63:0] FA = {30'd0, 2'b10, 16'h0F0F, 16'hA5A5};
    localparam logic [63:0] FB = {30'd0, 2'b01, 16'hFFFF, 16'h1234};
    localparam logic [63:0] F3_BAD  = {12'd0, 2'b00, 2'b11, 16'h0000, 16'h0000, 16'h0001};
    localparam logic [63:0] F3_GOOD = {12'd0, 2'b00, 2'b10, 16'h0000, 16'h0000, 16'h0001};

    initial begin
        int e, ed;
        bit sd, se;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_saidas", 64'(saidas), 64'd0);
        check("rst_outc", 64'(outc), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // good frame A, even parity needs 1 (17 ones in payload)
        pulse_start(1'b0, e);
        check("start_ready", 64'(ready), 64'd1);
        send_bits(FA, 34, -1, 0);
        send_bits(64'd1, 1, -1, 0);
        wait_result(1'b0, ed, sd, se);
        check("good_done", 64'(sd), 64'd1);
        check("good_err", 64'(se), 64'd0);
        check("good_latency", 64'(ed - e + 1), 64'd37);
        check("good_saidas", 64'(saidas), 64'h0F0F_A5A5);
        check("good_outc", 64'(outc), 64'b10);
        check("good_valid", 64'(valid), 64'd1);
        @(negedge clk);
        check("good_pulse_width", 64'(done), 64'd0);
        check("idle_ready", 64'(ready), 64'd0);

        // bad parity on frame A
        pulse_start(1'b0, e);
        send_bits(FA, 34, -1, 0);
        send_bits(64'd0, 1, -1, 0);
        wait_result(1'b0, ed, sd, se);
        check("badpar_err", 64'(se), 64'd1);
        check("badpar_done", 64'(sd), 64'd0);
        check("badpar_saidas", 64'(saidas), 64'h0F0F_A5A5);
        check("badpar_outc", 64'(outc), 64'b10);
        check("badpar_valid", 64'(valid), 64'd1);

        // restart after 10 junk bits, then frame B (22 ones -> parity 0)
        pulse_start(1'b0, e);
        send_bits(64'h3FF, 10, -1, 0);
        check("partial_no_result", 64'({done, err}), 64'd0);
        pulse_start(1'b0, e);
        send_bits(FB, 34, -1, 0);
        send_bits(64'd0, 1, -1, 0);
        wait_result(1'b0, ed, sd, se);
        check("restart_done", 64'(sd), 64'd1);
        check("restart_latency", 64'(ed - e + 1), 64'd37);
        check("restart_saidas", 64'(saidas), 64'hFFFF_1234);
        check("restart_outc", 64'(outc), 64'b01);

        // frame A with a 5-cycle valid gap after bit 12
        pulse_start(1'b0, e);
        send_bits(FA, 34, 12, 5);
        send_bits(64'd1, 1, -1, 0);
        wait_result(1'b0, ed, sd, se);
        check("gap_done", 64'(sd), 64'd1);
        check("gap_latency", 64'(ed - e + 1), 64'd42);
        check("gap_saidas", 64'(saidas), 64'h0F0F_A5A5);
        check("gap_outc", 64'(outc), 64'b10);

        // 3x1 geometry: selector 3 out of range (3 ones -> parity 1)
        pulse_start(1'b1, e);
        send_bits(F3_BAD, 52, -1, 0);
        send_bits(64'd1, 1, -1, 0);
        wait_result(1'b1, ed, sd, se);
        check("range_err", 64'(se), 64'd1);
        check("range_done", 64'(sd), 64'd0);
        check("range_outc", 64'(outc3), 64'd0);
        check("range_valid", 64'(valid3), 64'd0);

        // 3x1 geometry: selector 2 is legal (2 ones -> parity 0)
        pulse_start(1'b1, e);
        send_bits(F3_GOOD, 52, -1, 0);
        send_bits(64'd0, 1, -1, 0);
        wait_result(1'b1, ed, sd, se);
        check("range_ok_done", 64'(sd), 64'd1);
        check("range_ok_latency", 64'(ed - e + 1), 64'd55);
        check("range_ok_outc", 64'(outc3), 64'b0010);
        check("range_ok_saidas", 64'(saidas3), 64'h0000_0000_0001);

        // reset in the middle of a frame clears the committed chromosome
        pulse_start(1'b0, e);
        send_bits(FB, 8, -1, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_saidas", 64'(saidas), 64'd0);
        check("midrst_outc", 64'(outc), 64'd0);
        check("midrst_valid", 64'({valid, valid3}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(1'b0, e);
        send_bits(FA, 34, -1, 0);
        send_bits(64'd1, 1, -1, 0);
        wait_result(1'b0, ed, sd, se);
        check("postrst_done", 64'(sd), 64'd1);
        check("postrst_latency", 64'(ed - e + 1), 64'd37);
        check("postrst_saidas", 64'(saidas), 64'h0F0F_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
